// File: rtl/note_slot_sched.sv
// rtl/note_slot_sched.sv - note-track slot scheduler: spawn, scroll, hit judgment, miss retire, score counters
//
// Purpose: keeps a fixed pool of note slots for the on-screen note track.
//   On each frame tick every live slot scrolls left, and notes that have passed
//   the judgment window are retired as MISS. A spawn request claims the lowest
//   free slot. A drum hit starts a serial scan for the leftmost live note, which
//   is then judged GOOD/BAD when it lies inside the hit window.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   vsync        in   1-cycle frame tick
//   request      in   [0]=spawn do, [1]=spawn ka (sampled on vsync only)
//   hit_do       in   1-cycle drum-centre pulse
//   hit_ka       in   1-cycle drum-rim pulse
//   slot_valid   out  per-slot live flag
//   slot_type    out  per-slot type (0=do, 1=ka)
//   slot_x       out  per-slot x, slot i at [10*i+9:10*i]
//   judge_valid  out  1-cycle retire pulse
//   judge_result out  01=GOOD 10=BAD 11=MISS, 00 when idle
//   spawn_drop   out  1-cycle pulse when a spawn finds no free slot
//   good_cnt, bad_cnt, miss_cnt  out  saturating 8-bit score counters
module note_slot_sched #(
  parameter int SLOTS   = 8,
  parameter int X_START = 640,
  parameter int X_HIT   = 100,
  parameter int HIT_WIN = 16,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic [1:0]         request,
  input  logic               hit_do,
  input  logic               hit_ka,
  output logic [SLOTS-1:0]   slot_valid,
  output logic [SLOTS-1:0]   slot_type,
  output logic [10*SLOTS-1:0] slot_x,
  output logic               judge_valid,
  output logic [1:0]         judge_result,
  output logic               spawn_drop,
  output logic [7:0]         good_cnt,
  output logic [7:0]         bad_cnt,
  output logic [7:0]         miss_cnt
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SLOTS - 1);
  localparam logic [9:0] X_START10 = 10'(X_START);
  localparam logic [9:0] STEP10    = 10'(STEP);
  // Below this x a note can no longer be hit; it is also the window's low edge.
  localparam logic [9:0] WIN_LO    = 10'(X_HIT - HIT_WIN);
  localparam logic [9:0] WIN_HI    = 10'(X_HIT + HIT_WIN);

  typedef enum logic [1:0] {IDLE, SCAN, JUDGE} state_t;

  state_t state, state_nxt;

  logic [SLOTS-1:0] valid_q;
  logic [SLOTS-1:0] type_q;
  logic [9:0]       x_q [SLOTS];

  logic             hit_type;
  logic [IW-1:0]    idx;
  logic             cand_found;
  logic [IW-1:0]    cand_idx;
  logic [9:0]       cand_x;

  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic [SLOTS-1:0] miss_mask;
  logic             take;
  logic             judge_hit;
  logic             hit_any;

  assign slot_valid = valid_q;
  assign slot_type  = type_q;
  assign hit_any    = hit_do | hit_ka;

  for (genvar g = 0; g < SLOTS; g++) begin : g_x
    assign slot_x[10*g +: 10] = x_q[g];
  end

  // Free-slot search and miss detection both look at pre-update slot state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    miss_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      miss_mask[i] = valid_q[i] && (x_q[i] < WIN_LO);
    end
  end

  // Strict '<' keeps the lowest index on equal x.
  always_comb begin
    take = valid_q[idx] && (!cand_found || (x_q[idx] < cand_x));
  end

  // A frame update in the judge cycle discards the judgment.
  always_comb begin
    judge_hit = (state == JUDGE) && !vsync && cand_found &&
                (cand_x >= WIN_LO) && (cand_x <= WIN_HI);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit_any) state_nxt = SCAN;
      SCAN:    if (!vsync && idx == LAST_IDX) state_nxt = JUDGE;
      JUDGE:   state_nxt = vsync ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      type_q       <= '0;
      for (int i = 0; i < SLOTS; i++) x_q[i] <= '0;
      hit_type     <= 1'b0;
      idx          <= '0;
      cand_found   <= 1'b0;
      cand_idx     <= '0;
      cand_x       <= '0;
      judge_valid  <= 1'b0;
      judge_result <= 2'b00;
      spawn_drop   <= 1'b0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      judge_valid  <= 1'b0;
      judge_result <= 2'b00;
      spawn_drop   <= 1'b0;

      if (vsync) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (valid_q[i]) begin
            if (miss_mask[i]) begin
              valid_q[i] <= 1'b0;
              type_q[i]  <= 1'b0;
              x_q[i]     <= '0;
            end else begin
              x_q[i] <= (x_q[i] >= STEP10) ? (x_q[i] - STEP10) : '0;
            end
          end
        end
        // Any number of misses in one frame collapses to one pulse and one count.
        if (|miss_mask) begin
          judge_valid  <= 1'b1;
          judge_result <= 2'b11;
          if (miss_cnt != 8'hff) miss_cnt <= miss_cnt + 8'd1;
        end
        // The chosen slot was free, so the scroll loop above never touched it.
        if (request != 2'b00) begin
          if (free_found) begin
            valid_q[free_idx] <= 1'b1;
            type_q[free_idx]  <= (request == 2'b10);
            x_q[free_idx]     <= X_START10;
          end else begin
            spawn_drop <= 1'b1;
          end
        end
      end else if (judge_hit) begin
        valid_q[cand_idx] <= 1'b0;
        type_q[cand_idx]  <= 1'b0;
        x_q[cand_idx]     <= '0;
        judge_valid       <= 1'b1;
        if (type_q[cand_idx] == hit_type) begin
          judge_result <= 2'b01;
          if (good_cnt != 8'hff) good_cnt <= good_cnt + 8'd1;
        end else begin
          judge_result <= 2'b10;
          if (bad_cnt != 8'hff) bad_cnt <= bad_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (hit_any) begin
            hit_type   <= hit_ka & ~hit_do;
            idx        <= '0;
            cand_found <= 1'b0;
          end
        end
        SCAN: begin
          if (vsync) begin
            idx        <= '0;
            cand_found <= 1'b0;
          end else begin
            if (take) begin
              cand_found <= 1'b1;
              cand_idx   <= idx;
              cand_x     <= x_q[idx];
            end
            idx <= idx + IW'(1);
          end
        end
        JUDGE: begin
          idx        <= '0;
          cand_found <= 1'b0;
        end
        default: begin
          idx        <= '0;
          cand_found <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_slot_sched.sv
// tb/tb_note_slot_sched.sv - directed self-checking bench for note_slot_sched
module tb_note_slot_sched;

  logic        clk;
  logic        rst;
  logic        vsync;
  logic [1:0]  request;
  logic        hit_do;
  logic        hit_ka;
  logic [7:0]  slot_valid;
  logic [7:0]  slot_type;
  logic [79:0] slot_x;
  logic        judge_valid;
  logic [1:0]  judge_result;
  logic        spawn_drop;
  logic [7:0]  good_cnt;
  logic [7:0]  bad_cnt;
  logic [7:0]  miss_cnt;

  int tests;
  int fails;

  note_slot_sched dut (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .request      (request),
    .hit_do       (hit_do),
    .hit_ka       (hit_ka),
    .slot_valid   (slot_valid),
    .slot_type    (slot_type),
    .slot_x       (slot_x),
    .judge_valid  (judge_valid),
    .judge_result (judge_result),
    .spawn_drop   (spawn_drop),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] xs(input int i);
    return slot_x[10*i +: 10];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; vsync = 1'b0; request = 2'b00; hit_do = 1'b0; hit_ka = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_vsync(input logic [1:0] req);
    @(negedge clk);
    vsync = 1'b1; request = req;
    @(negedge clk);
    vsync = 1'b0; request = 2'b00;
  endtask

  task automatic scroll(input int n);
    for (int i = 0; i < n; i++) do_vsync(2'b00);
  endtask

  // Pulses a hit and returns the count of posedges (hit sample edge = 1)
  // after which judge_valid was first seen, or 0 if none within budget.
  task automatic hit_and_wait(input logic d, input logic k, input int vs_at,
                              input int budget, output int seen, output logic [1:0] res);
    seen = 0; res = 2'b00;
    @(negedge clk);
    hit_do = d; hit_ka = k;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      hit_do = 1'b0; hit_ka = 1'b0;
      vsync = 1'b0;
      if (judge_valid && seen == 0) begin
        seen = c; res = judge_result;
      end
      if (c == vs_at) vsync = 1'b1;
    end
    vsync = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (slot_valid !== 8'h00 || slot_type !== 8'h00 || slot_x !== 80'd0) begin
      fails++; $display("FAIL reset_slots: valid=%h type=%h x=%h want 0", slot_valid, slot_type, slot_x);
    end
    tests++;
    if (judge_valid !== 1'b0 || judge_result !== 2'b00 || spawn_drop !== 1'b0 ||
        good_cnt !== 8'd0 || bad_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_outputs: jv=%b jr=%b sd=%b g=%0d b=%0d m=%0d want 0",
                        judge_valid, judge_result, spawn_drop, good_cnt, bad_cnt, miss_cnt);
    end
  endtask

  task automatic test_spawn_scroll();
    do_reset();
    do_vsync(2'b01);
    tests++;
    if (slot_valid !== 8'h01 || slot_type[0] !== 1'b0 || xs(0) !== 10'd640) begin
      fails++; $display("FAIL spawn_first: valid=%h type0=%b x0=%0d want 01/0/640", slot_valid, slot_type[0], xs(0));
    end
    scroll(8);
    tests++;
    if (xs(0) !== 10'd608 || slot_valid !== 8'h01) begin
      fails++; $display("FAIL scroll_8: x0=%0d valid=%h want 608/01", xs(0), slot_valid);
    end
  endtask

  task automatic test_spawn_drop();
    do_reset();
    for (int i = 0; i < 8; i++) do_vsync((i == 3) ? 2'b11 : 2'b01);
    tests++;
    if (slot_valid !== 8'hff || slot_type !== 8'h00 || xs(0) !== 10'd612 || xs(7) !== 10'd640) begin
      fails++; $display("FAIL fill_8: valid=%h type=%h x0=%0d x7=%0d want ff/00/612/640",
                        slot_valid, slot_type, xs(0), xs(7));
    end
    do_vsync(2'b10);
    tests++;
    if (spawn_drop !== 1'b1) begin
      fails++; $display("FAIL drop_pulse: spawn_drop=%b want 1", spawn_drop);
    end
    tests++;
    if (slot_valid !== 8'hff || slot_type !== 8'h00 || xs(0) !== 10'd608 || xs(7) !== 10'd636) begin
      fails++; $display("FAIL drop_slots: valid=%h type=%h x0=%0d x7=%0d want ff/00/608/636",
                        slot_valid, slot_type, xs(0), xs(7));
    end
    @(negedge clk);
    tests++;
    if (spawn_drop !== 1'b0) begin
      fails++; $display("FAIL drop_one_cycle: spawn_drop=%b want 0", spawn_drop);
    end
  endtask

  task automatic test_good();
    int seen; logic [1:0] res;
    do_reset();
    do_vsync(2'b01);
    scroll(135);
    tests++;
    if (xs(0) !== 10'd100) begin
      fails++; $display("FAIL good_setup: x0=%0d want 100", xs(0));
    end
    hit_and_wait(1'b1, 1'b0, 0, 14, seen, res);
    tests++;
    if (seen !== 10 || res !== 2'b01) begin
      fails++; $display("FAIL good_latency: seen_at=%0d result=%b want 10/01", seen, res);
    end
    tests++;
    if (slot_valid[0] !== 1'b0 || good_cnt !== 8'd1 || bad_cnt !== 8'd0) begin
      fails++; $display("FAIL good_retire: valid0=%b good=%0d bad=%0d want 0/1/0", slot_valid[0], good_cnt, bad_cnt);
    end
  endtask

  task automatic test_bad_and_window();
    int seen; logic [1:0] res;
    do_reset();
    do_vsync(2'b10);
    tests++;
    if (slot_type[0] !== 1'b1) begin
      fails++; $display("FAIL ka_type: type0=%b want 1", slot_type[0]);
    end
    scroll(132);
    hit_and_wait(1'b1, 1'b0, 0, 14, seen, res);
    tests++;
    if (seen !== 10 || res !== 2'b10 || bad_cnt !== 8'd1 || slot_valid[0] !== 1'b0) begin
      fails++; $display("FAIL bad_judge: seen_at=%0d result=%b bad=%0d valid0=%b want 10/10/1/0",
                        seen, res, bad_cnt, slot_valid[0]);
    end
    do_vsync(2'b01);
    scroll(130);
    hit_and_wait(1'b1, 1'b0, 0, 14, seen, res);
    tests++;
    if (seen !== 0 || slot_valid[0] !== 1'b1 || xs(0) !== 10'd120 || good_cnt !== 8'd0) begin
      fails++; $display("FAIL outside_window: seen_at=%0d valid0=%b x0=%0d good=%0d want 0/1/120/0",
                        seen, slot_valid[0], xs(0), good_cnt);
    end
    scroll(1);
    hit_and_wait(1'b1, 1'b1, 0, 14, seen, res);
    tests++;
    if (seen !== 10 || res !== 2'b01 || good_cnt !== 8'd1 || slot_valid[0] !== 1'b0) begin
      fails++; $display("FAIL edge_116_both_hits: seen_at=%0d result=%b good=%0d valid0=%b want 10/01/1/0",
                        seen, res, good_cnt, slot_valid[0]);
    end
  endtask

  task automatic test_miss();
    do_reset();
    do_vsync(2'b01);
    scroll(139);
    tests++;
    if (xs(0) !== 10'd84) begin
      fails++; $display("FAIL miss_setup: x0=%0d want 84", xs(0));
    end
    do_vsync(2'b00);
    tests++;
    if (judge_valid !== 1'b0 || xs(0) !== 10'd80 || slot_valid[0] !== 1'b1) begin
      fails++; $display("FAIL miss_at_84: jv=%b x0=%0d valid0=%b want 0/80/1", judge_valid, xs(0), slot_valid[0]);
    end
    do_vsync(2'b00);
    tests++;
    if (judge_valid !== 1'b1 || judge_result !== 2'b11 || miss_cnt !== 8'd1 || slot_valid[0] !== 1'b0) begin
      fails++; $display("FAIL miss_pulse: jv=%b jr=%b miss=%0d valid0=%b want 1/11/1/0",
                        judge_valid, judge_result, miss_cnt, slot_valid[0]);
    end
    @(negedge clk);
    tests++;
    if (judge_valid !== 1'b0 || judge_result !== 2'b00) begin
      fails++; $display("FAIL miss_one_cycle: jv=%b jr=%b want 0/00", judge_valid, judge_result);
    end
  endtask

  task automatic test_restart_and_reset();
    int seen; logic [1:0] res;
    do_reset();
    do_vsync(2'b01);
    scroll(135);
    // vsync sampled on the 4th edge; the note moves to 96, still in window.
    hit_and_wait(1'b0, 1'b1, 3, 18, seen, res);
    tests++;
    if (seen !== 13 || res !== 2'b10 || bad_cnt !== 8'd1 || slot_valid[0] !== 1'b0) begin
      fails++; $display("FAIL restart_latency: seen_at=%0d result=%b bad=%0d valid0=%b want 13/10/1/0",
                        seen, res, bad_cnt, slot_valid[0]);
    end
    do_vsync(2'b01);
    scroll(135);
    @(negedge clk);
    hit_do = 1'b1;
    @(negedge clk);
    hit_do = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (judge_valid) seen = 1;
    end
    tests++;
    if (seen !== 0 || good_cnt !== 8'd0 || bad_cnt !== 8'd0 || slot_valid !== 8'h00) begin
      fails++; $display("FAIL reset_mid_scan: pulse=%0d good=%0d bad=%0d valid=%h want 0/0/0/00",
                        seen, good_cnt, bad_cnt, slot_valid);
    end
    do_vsync(2'b01);
    scroll(135);
    hit_and_wait(1'b1, 1'b0, 0, 14, seen, res);
    tests++;
    if (seen !== 10 || res !== 2'b01 || good_cnt !== 8'd1) begin
      fails++; $display("FAIL after_reset_hit: seen_at=%0d result=%b good=%0d want 10/01/1", seen, res, good_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; vsync = 1'b0; request = 2'b00; hit_do = 1'b0; hit_ka = 1'b0;
    test_reset();
    test_spawn_scroll();
    test_spawn_drop();
    test_good();
    test_bad_and_window();
    test_miss();
    test_restart_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
